// File: rtl/mad_seq_ctrl_if.sv
// Handshake bundle between issue logic, mad_seq_ctrl and one mad instance.
// slave = sequencer side, master = issue/mad side.
interface mad_seq_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_len_i;
  logic [31:0]      cmd_acc_init_i;
  logic             opnd_valid_i;
  logic             opnd_ready_o;
  logic [31:0]      opnd_a_i;
  logic [31:0]      opnd_b_i;
  logic             mad_valid_o;
  logic [31:0]      mad_operand_a_o;
  logic [31:0]      mad_operand_b_o;
  logic             mad_result_valid_i;
  logic [31:0]      mad_result_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [31:0]      res_data_o;
  logic             res_sat_o;
  logic             busy_o;

  modport slave (
    input  cmd_valid_i, cmd_len_i, cmd_acc_init_i,
    input  opnd_valid_i, opnd_a_i, opnd_b_i,
    input  mad_result_valid_i, mad_result_i,
    input  res_ready_i,
    output cmd_ready_o, opnd_ready_o,
    output mad_valid_o, mad_operand_a_o, mad_operand_b_o,
    output res_valid_o, res_data_o, res_sat_o, busy_o
  );

  modport master (
    output cmd_valid_i, cmd_len_i, cmd_acc_init_i,
    output opnd_valid_i, opnd_a_i, opnd_b_i,
    output mad_result_valid_i, mad_result_i,
    output res_ready_i,
    input  cmd_ready_o, opnd_ready_o,
    input  mad_valid_o, mad_operand_a_o, mad_operand_b_o,
    input  res_valid_o, res_data_o, res_sat_o, busy_o
  );
endinterface

// File: rtl/mad_seq_ctrl.sv
// Sequencer feeding one mad unit and accumulating its partial sums.
// Define MAD_SEQ_SAT_EN for a signed-saturating accumulator with sticky flag.
module mad_seq_ctrl #(
  parameter int LEN_W       = 8,
  parameter int MAD_LATENCY = 2
) (
  input logic           clk_i,
  input logic           rst_ni,
  mad_seq_ctrl_if.slave bus
);

  if (MAD_LATENCY < 1) begin : g_bad_latency
    $error("mad_seq_ctrl: MAD_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] retired;
  logic [LEN_W-1:0] issued_nxt;
  logic [LEN_W-1:0] retired_nxt;
  logic [31:0]      acc;
  logic [31:0]      acc_add;
  logic             cmd_hs;
  logic             issue;
  logic             retire;

  assign cmd_hs      = (state == IDLE) & bus.cmd_valid_i;
  assign bus.opnd_ready_o = (state == ISSUE) & (issued < len);
  assign issue       = bus.opnd_valid_i & bus.opnd_ready_o;
  assign retire      = bus.mad_result_valid_i
                     & ((state == ISSUE) | (state == DRAIN));
  assign issued_nxt  = issued + 1'b1;
  assign retired_nxt = retired + 1'b1;

`ifdef MAD_SEQ_SAT_EN
  logic [32:0] wide;
  logic        ovf;
  logic        sat;

  always_comb begin
    wide    = {acc[31], acc}
            + {bus.mad_result_i[31], bus.mad_result_i};
    ovf     = wide[32] ^ wide[31];
    acc_add = wide[31:0];
    if (ovf) acc_add = wide[32] ? 32'h8000_0000 : 32'h7fff_ffff;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            sat <= 1'b0;
    else if (cmd_hs)        sat <= 1'b0;
    else if (retire && ovf) sat <= 1'b1;
  end

  assign bus.res_sat_o = sat;
`else
  assign acc_add       = acc + bus.mad_result_i;
  assign bus.res_sat_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      len     <= '0;
      issued  <= '0;
      retired <= '0;
      acc     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            acc     <= bus.cmd_acc_init_i;
            len     <= bus.cmd_len_i;
            issued  <= '0;
            retired <= '0;
            state   <= (bus.cmd_len_i == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            issued <= issued_nxt;
            if (issued_nxt == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave on the edge that retires the last partial sum
          if ((retire && retired_nxt == len) || retired == len)
            state <= DONE;
        end
        DONE: begin
          if (bus.res_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (retire) begin
        acc     <= acc_add;
        retired <= retired_nxt;
      end
    end
  end

  assign bus.cmd_ready_o     = (state == IDLE);
  assign bus.mad_valid_o     = issue;
  assign bus.mad_operand_a_o = bus.opnd_a_i;
  assign bus.mad_operand_b_o = bus.opnd_b_i;
  assign bus.res_valid_o     = (state == DONE);
  assign bus.res_data_o      = acc;
  assign bus.busy_o          = (state != IDLE);

endmodule

// File: tb/tb_mad_seq_ctrl.sv
// Bench for mad_seq_ctrl: behavioural 2-cycle mad plus result scoreboard.
// Define MAD_SEQ_SAT_EN here too when building the saturating variant.
module tb_mad_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mad_seq_ctrl_if #(.LEN_W(8)) bus();

  mad_seq_ctrl #(
    .LEN_W(8),
    .MAD_LATENCY(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic        sat;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] dot(input logic [31:0] a,
                                      input logic [31:0] b);
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      int ua = a[8*k+:8];
      int sbv = $signed(b[8*k+:8]);
      s += ua * sbv;
    end
    return s;
  endfunction

  function automatic exp_t model(input int len, input logic [31:0] init,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] p;
    longint w;
    e.data = init;
    e.sat = 1'b0;
    p = dot(a, b);
    for (int i = 0; i < len; i++) begin
`ifdef MAD_SEQ_SAT_EN
      w = longint'($signed(e.data)) + longint'($signed(p));
      if (w > 64'sd2147483647) begin
        e.data = 32'h7fff_ffff;
        e.sat = 1'b1;
      end else if (w < -64'sd2147483648) begin
        e.data = 32'h8000_0000;
        e.sat = 1'b1;
      end else begin
        e.data = w[31:0];
      end
`else
      w = 0;
      e.data = e.data + p;
`endif
    end
    return e;
  endfunction

  // Behavioural mad: 2-stage pipeline, reset shared with the DUT
  logic        p1_v, p2_v;
  logic [31:0] p1_d, p2_d;
  logic        inj_v = 1'b0;
  logic [31:0] inj_d = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0;
      p2_v <= 1'b0;
      p1_d <= '0;
      p2_d <= '0;
    end else begin
      p1_v <= bus.mad_valid_o;
      p1_d <= dot(bus.mad_operand_a_o, bus.mad_operand_b_o);
      p2_v <= p1_v;
      p2_d <= p1_d;
    end
  end

  assign bus.mad_result_valid_i = p2_v | inj_v;
  assign bus.mad_result_i       = inj_v ? inj_d : p2_d;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input string nm, input int len,
                        input logic [31:0] init, input logic [31:0] a,
                        input logic [31:0] b, input int gap,
                        input int hold);
    exp_t e;
    exp_t got;
    int last_iss;
    int w;
    sb.push_back(model(len, init, a, b));
    bus.cmd_valid_i    = 1'b1;
    bus.cmd_len_i      = len[7:0];
    bus.cmd_acc_init_i = init;
    last_iss = cyc;
    step;
    bus.cmd_valid_i = 1'b0;
    n_cmp++;
    if (bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy: got %b want 1", nm, bus.busy_o);
    end
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          bus.opnd_valid_i = 1'b0;
          step;
        end
      end
      bus.opnd_valid_i = 1'b1;
      bus.opnd_a_i = a;
      bus.opnd_b_i = b;
      w = 0;
      while (bus.opnd_ready_o !== 1'b1 && w < 20) begin
        step;
        w++;
      end
      if (w >= 20) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s opnd_ready timeout: got 0 want 1", nm);
      end
      last_iss = cyc;
      step;
    end
    bus.opnd_valid_i = 1'b0;
    if (len > 0) begin
      n_cmp++;
      if (bus.opnd_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s opnd_ready after last: got %b want 0",
                 nm, bus.opnd_ready_o);
      end
    end
    w = 0;
    while (bus.res_valid_o !== 1'b1 && w < 50) begin
      step;
      w++;
    end
    n_cmp++;
    if (bus.res_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s res_valid timeout: got 0 want 1", nm);
      void'(sb.pop_front());
      return;
    end
    n_cmp++;
    if (cyc - last_iss !== ((len == 0) ? 1 : 3)) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", nm,
               cyc - last_iss, (len == 0) ? 1 : 3);
    end
    repeat (hold) begin
      step;
      n_cmp++;
      if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== sb[0].data ||
          bus.cmd_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold: got v=%b d=%h cr=%b want v=1 d=%h cr=0",
                 nm, bus.res_valid_o, bus.res_data_o, bus.cmd_ready_o,
                 sb[0].data);
      end
    end
    n_cmp++;
    if (bus.cmd_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s cmd_ready in done: got %b want 0",
               nm, bus.cmd_ready_o);
    end
    bus.res_ready_i = 1'b1;
    got.data = bus.res_data_o;
    got.sat  = bus.res_sat_o;
    step;
    bus.res_ready_i = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (got.data !== e.data || got.sat !== e.sat) begin
      n_err++;
      $display("FAIL %s result: got %h sat=%b want %h sat=%b",
               nm, got.data, got.sat, e.data, e.sat);
    end
    n_cmp++;
    if (bus.cmd_ready_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s after done: got cr=%b rv=%b want cr=1 rv=0",
               nm, bus.cmd_ready_o, bus.res_valid_o);
    end
  endtask

  task automatic check_idle(input string nm);
    n_cmp++;
    if (bus.cmd_ready_o !== 1'b1 || bus.opnd_ready_o !== 1'b0 ||
        bus.mad_valid_o !== 1'b0 || bus.res_valid_o !== 1'b0 ||
        bus.res_data_o !== 32'h0 || bus.res_sat_o !== 1'b0 ||
        bus.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got cr=%b or=%b mv=%b rv=%b d=%h s=%b bz=%b want 1 0 0 0 0 0 0",
               nm, bus.cmd_ready_o, bus.opnd_ready_o, bus.mad_valid_o,
               bus.res_valid_o, bus.res_data_o, bus.res_sat_o, bus.busy_o);
    end
  endtask

  task automatic test_reset;
    repeat (2) step;
    check_idle("reset");
    rst_n = 1'b1;
    step;
    check_idle("post_reset");
  endtask

  task automatic test_ignore_idle;
    inj_v = 1'b1;
    inj_d = 32'h0000_0055;
    step;
    inj_v = 1'b0;
    step;
    check_idle("idle_result_ignored");
    do_cmd("idle_then_len0", 0, 32'h99, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_single;
    do_cmd("single", 1, 32'h0, 32'h0101_0101, 32'h0202_0202, 0, 0);
  endtask

  task automatic test_burst;
    do_cmd("burst3", 3, 32'd10, 32'h0101_0101, 32'h0202_0202, 0, 0);
  endtask

  task automatic test_bubble;
    do_cmd("bubble", 2, 32'h0, 32'h0101_0101, 32'hffff_ffff, 3, 0);
  endtask

  task automatic test_len0;
    do_cmd("len0_hold", 0, 32'h1234, 32'h0, 32'h0, 0, 5);
  endtask

  task automatic test_sat;
    do_cmd("sat_edge", 1, 32'h7fff_fff0, 32'hffff_ffff, 32'h7f7f_7f7f, 0, 0);
    do_cmd("neg_edge", 2, 32'h8000_0010, 32'hffff_ffff, 32'h8080_8080, 0, 1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      do_cmd("b2b", $urandom_range(1, 6), $urandom, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    bus.cmd_valid_i    = 1'b1;
    bus.cmd_len_i      = 8'd1;
    bus.cmd_acc_init_i = 32'd5;
    step;
    bus.cmd_valid_i  = 1'b0;
    bus.opnd_valid_i = 1'b1;
    bus.opnd_a_i     = 32'h0101_0101;
    bus.opnd_b_i     = 32'h0303_0303;
    step;
    bus.opnd_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle("reset_mid");
    #2;
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      step;
      if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got %0d bad cycles want 0", bad);
    end
    do_cmd("after_reset", 2, 32'd7, 32'h0101_0101, 32'h0303_0303, 0, 0);
  endtask

  initial begin
    bus.cmd_valid_i    = 1'b0;
    bus.cmd_len_i      = '0;
    bus.cmd_acc_init_i = '0;
    bus.opnd_valid_i   = 1'b0;
    bus.opnd_a_i       = '0;
    bus.opnd_b_i       = '0;
    bus.res_ready_i    = 1'b0;
    test_reset;
    test_ignore_idle;
    test_single;
    test_burst;
    test_bubble;
    test_len0;
    test_sat;
    test_back_to_back;
    test_reset_mid;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
